// File: rtl/led_seq_pkg.sv
// Shared mode codes and sequencer state encoding for the LED pattern block.
package led_seq_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_CHASE = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SOLID = 3'd1;
    localparam logic [2:0] ST_ON    = 3'd2;
    localparam logic [2:0] ST_OFF   = 3'd3;
    localparam logic [2:0] ST_STEP  = 3'd4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle every TICK_DIV cycles.
// clear restarts the count at 0 so the next tick lands exactly TICK_DIV cycles later.
module tick_prescaler #(
    parameter int TICK_DIV = 4194304
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    always_comb begin
        count_d = count_q + CW'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Sole driver of the LED bank: solid, blink and chase patterns timed by a prescaler tick.
// led follows an accepted command one cycle later; cmd_ready drops only while a finite pattern runs.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV = 4194304,
    parameter int NUM_LEDS = 8,
    parameter int CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [NUM_LEDS-1:0] cmd_mask,
    input  logic [CNT_W-1:0]    cmd_repeat,
    input  logic [CNT_W-1:0]    cmd_on_ticks,
    input  logic [CNT_W-1:0]    cmd_off_ticks,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                done
);

    logic [2:0]          state_q,   state_d;
    logic [NUM_LEDS-1:0] led_q,     led_d;
    logic [NUM_LEDS-1:0] mask_q,    mask_d;
    logic [CNT_W-1:0]    rpt_q,     rpt_d;
    logic [CNT_W-1:0]    on_len_q,  on_len_d;
    logic [CNT_W-1:0]    off_len_q, off_len_d;
    logic [CNT_W-1:0]    phase_q,   phase_d;
    logic [CNT_W-1:0]    rep_q,     rep_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic                accept;
    logic                tick;
    logic                finite;
    logic                last_rep;
    logic                phase_end;
    logic [CNT_W-1:0]    cur_len;
    logic [NUM_LEDS-1:0] led_rot;

    function automatic logic [CNT_W-1:0] nz_len(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .tick  (tick)
    );

    // busy_q is set exactly while a finite pattern owns the bank, so it doubles as the lockout.
    assign cmd_ready = ~rst & ~busy_q;
    assign accept    = cmd_valid & cmd_ready;

    // Counters compare against length-1 so the maximum field value never needs a wider counter.
    assign finite    = (rpt_q != '0);
    assign last_rep  = finite && (rep_q == rpt_q - CNT_W'(1));
    assign cur_len   = (state_q == ST_OFF) ? off_len_q : on_len_q;
    assign phase_end = (phase_q == cur_len - CNT_W'(1));
    assign led_rot   = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};

    always_comb begin
        state_d   = state_q;
        led_d     = led_q;
        mask_d    = mask_q;
        rpt_d     = rpt_q;
        on_len_d  = on_len_q;
        off_len_d = off_len_q;
        phase_d   = phase_q;
        rep_d     = rep_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (accept) begin
            mask_d    = cmd_mask;
            rpt_d     = cmd_repeat;
            on_len_d  = nz_len(cmd_on_ticks);
            off_len_d = nz_len(cmd_off_ticks);
            phase_d   = '0;
            rep_d     = '0;
            case (cmd_mode)
                MODE_SOLID: begin
                    state_d = ST_SOLID;
                    led_d   = cmd_mask;
                    busy_d  = 1'b0;
                end
                MODE_BLINK: begin
                    state_d = ST_ON;
                    led_d   = cmd_mask;
                    busy_d  = (cmd_repeat != '0);
                end
                MODE_CHASE: begin
                    state_d = ST_STEP;
                    led_d   = cmd_mask;
                    busy_d  = (cmd_repeat != '0);
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end else if (tick) begin
            case (state_q)
                ST_ON: begin
                    if (phase_end) begin
                        phase_d = '0;
                        state_d = ST_OFF;
                        led_d   = '0;
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (phase_end) begin
                        phase_d = '0;
                        if (last_rep) begin
                            state_d = ST_IDLE;
                            led_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_ON;
                            led_d   = mask_q;
                            if (finite) begin
                                rep_d = rep_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                ST_STEP: begin
                    if (phase_end) begin
                        phase_d = '0;
                        if (last_rep) begin
                            state_d = ST_IDLE;
                            led_d   = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            led_d = led_rot;
                            if (finite) begin
                                rep_d = rep_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            led_q     <= '0;
            mask_q    <= '0;
            rpt_q     <= '0;
            on_len_q  <= CNT_W'(1);
            off_len_q <= CNT_W'(1);
            phase_q   <= '0;
            rep_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            led_q     <= led_d;
            mask_q    <= mask_d;
            rpt_q     <= rpt_d;
            on_len_q  <= on_len_d;
            off_len_q <= off_len_d;
            phase_q   <= phase_d;
            rep_q     <= rep_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed vector table, corner sequences and random commands vs a trace model.
module tb_led_pattern_sequencer;

    localparam int TD = 4;
    localparam int NL = 8;
    localparam int CW = 4;

    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_SOLID = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_CHASE = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_mode = 2'd0;
    logic [NL-1:0] cmd_mask = '0;
    logic [CW-1:0] cmd_repeat = '0;
    logic [CW-1:0] cmd_on_ticks = '0;
    logic [CW-1:0] cmd_off_ticks = '0;
    logic [NL-1:0] led;
    logic          busy;
    logic          done;

    led_pattern_sequencer #(
        .TICK_DIV (TD),
        .NUM_LEDS (NL),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_mode      (cmd_mode),
        .cmd_mask      (cmd_mask),
        .cmd_repeat    (cmd_repeat),
        .cmd_on_ticks  (cmd_on_ticks),
        .cmd_off_ticks (cmd_off_ticks),
        .led           (led),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] led;
        logic          busy;
        logic          done;
        logic          rdy;
    } obs_t;

    typedef struct {
        string         name;
        logic [1:0]    mode;
        logic [NL-1:0] mask;
        logic [CW-1:0] rpt;
        logic [CW-1:0] on;
        logic [CW-1:0] off;
        int            ncyc;
        int            exp_done_at;
    } vec_t;

    obs_t exp_q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;

    function automatic obs_t mk(input logic [NL-1:0] l, input logic b, input logic d, input logic r);
        obs_t o;
        o.led  = l;
        o.busy = b;
        o.done = d;
        o.rdy  = r;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input int idx, input obs_t exp);
        obs_t act;
        act = {led, busy, done, cmd_ready};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got led=%h busy=%b done=%b rdy=%b, want led=%h busy=%b done=%b rdy=%b",
                     name, idx, act.led, act.busy, act.done, act.rdy,
                     exp.led, exp.busy, exp.done, exp.rdy);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Expected per-cycle trace starting the cycle after the accept edge, built from the pattern rules.
    task automatic build_trace(input logic [1:0] mode, input logic [NL-1:0] mask, input logic [CW-1:0] rpt,
                               input logic [CW-1:0] on, input logic [CW-1:0] off, input int ncyc);
        int            onl;
        int            offl;
        bit            fin;
        logic [NL-1:0] cur;
        exp_q.delete();
        onl = (on == 0) ? 1 : int'(on);
        offl = (off == 0) ? 1 : int'(off);
        fin = (rpt != 0);
        cur = mask;
        case (mode)
            M_OFF:   repeat (ncyc) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1));
            M_SOLID: repeat (ncyc) exp_q.push_back(mk(mask, 1'b0, 1'b0, 1'b1));
            M_BLINK: begin
                for (int f = 0; fin ? (f < int'(rpt)) : (exp_q.size() < ncyc); f++) begin
                    repeat (onl * TD) exp_q.push_back(mk(mask, fin, 1'b0, !fin));
                    repeat (offl * TD) exp_q.push_back(mk('0, fin, 1'b0, !fin));
                end
            end
            default: begin
                for (int s = 0; fin ? (s < int'(rpt)) : (exp_q.size() < ncyc); s++) begin
                    repeat (onl * TD) exp_q.push_back(mk(cur, fin, 1'b0, !fin));
                    cur = {cur[NL-2:0], cur[NL-1]};
                end
            end
        endcase
        if ((mode == M_BLINK || mode == M_CHASE) && fin) begin
            exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b1));
        end else begin
            while (exp_q.size() > ncyc) void'(exp_q.pop_back());
        end
    endtask

    task automatic accept_cmd(input logic [1:0] mode, input logic [NL-1:0] mask, input logic [CW-1:0] rpt,
                              input logic [CW-1:0] on, input logic [CW-1:0] off, input int ncyc);
        build_trace(mode, mask, rpt, on, off, ncyc);
        cmd_mode = mode;
        cmd_mask = mask;
        cmd_repeat = rpt;
        cmd_on_ticks = on;
        cmd_off_ticks = off;
        cmd_valid = 1'b1;
        #1;
        check_val("ready_pre_accept", int'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        cmd_mode = 2'($urandom);
        cmd_mask = NL'($urandom);
        cmd_repeat = CW'($urandom);
        cmd_on_ticks = CW'($urandom);
        cmd_off_ticks = CW'($urandom);
    endtask

    task automatic check_trace(input string name, input int n, output int done_at);
        done_at = -1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            check_obs(name, i, exp_q[i]);
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
    endtask

    initial begin
        int done_at;
        vecs.push_back('{"solid04",     M_SOLID, 8'h04, 4'd0,  4'd0, 4'd0, 100, -1});
        vecs.push_back('{"blink_ff",    M_BLINK, 8'hFF, 4'd3,  4'd2, 4'd1, 0,   36});
        vecs.push_back('{"chase81",     M_CHASE, 8'h81, 4'd2,  4'd1, 4'd0, 0,   8});
        vecs.push_back('{"blink_ever",  M_BLINK, 8'h0F, 4'd0,  4'd3, 4'd2, 6,   -1});
        vecs.push_back('{"preempt10",   M_SOLID, 8'h10, 4'd0,  4'd0, 4'd0, 5,   -1});
        vecs.push_back('{"chase_zero",  M_CHASE, 8'h00, 4'd3,  4'd1, 4'd0, 0,   12});
        vecs.push_back('{"off_cmd",     M_OFF,   8'hFF, 4'd5,  4'd1, 4'd1, 4,   -1});
        vecs.push_back('{"chase_ever",  M_CHASE, 8'h01, 4'd0,  4'd2, 4'd0, 40,  -1});
        vecs.push_back('{"blink_a5",    M_BLINK, 8'hA5, 4'd15, 4'd1, 4'd2, 0,   180});
        vecs.push_back('{"chase_wrap",  M_CHASE, 8'h80, 4'd15, 4'd0, 4'd0, 0,   60});
        vecs.push_back('{"blink_edge",  M_BLINK, 8'hFF, 4'd15, 4'd0, 4'd0, 0,   120});

        rst = 1'b1;
        #1;
        check_val("ready_in_reset", int'(cmd_ready), 0);
        repeat (2) begin
            step();
            check_obs("reset_state", 0, mk('0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;

        foreach (vecs[v]) begin
            accept_cmd(vecs[v].mode, vecs[v].mask, vecs[v].rpt, vecs[v].on, vecs[v].off, vecs[v].ncyc);
            check_trace(vecs[v].name, exp_q.size(), done_at);
            check_val({vecs[v].name, "_done_at"}, done_at, vecs[v].exp_done_at);
        end

        // A command held valid through a finite pattern is taken only on the done cycle.
        build_trace(M_BLINK, 8'h3C, 4'd15, 4'd0, 4'd0, 0);
        cmd_mode = M_BLINK;
        cmd_mask = 8'h3C;
        cmd_repeat = 4'd15;
        cmd_on_ticks = 4'd0;
        cmd_off_ticks = 4'd0;
        cmd_valid = 1'b1;
        step();
        cmd_mode = M_SOLID;
        cmd_mask = 8'h5A;
        check_trace("held_valid", exp_q.size(), done_at);
        check_val("held_valid_done_at", done_at, 120);
        step();
        check_obs("held_valid_taken", 0, mk(8'h5A, 1'b0, 1'b0, 1'b1));
        cmd_valid = 1'b0;

        // Reset in the middle of a finite blink.
        accept_cmd(M_BLINK, 8'hFF, 4'd3, 4'd2, 4'd1, 0);
        check_trace("pre_reset", 10, done_at);
        rst = 1'b1;
        #1;
        check_val("ready_during_rst", int'(cmd_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_obs("mid_reset", i, mk('0, 1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        #1;
        check_obs("rst_release", 0, mk('0, 1'b0, 1'b0, 1'b1));
        step();
        check_obs("rst_release", 1, mk('0, 1'b0, 1'b0, 1'b1));

        for (int r = 0; r < 40; r++) begin
            logic [1:0]    m;
            logic [NL-1:0] k;
            logic [CW-1:0] rp;
            logic [CW-1:0] on;
            logic [CW-1:0] off;
            m   = 2'($urandom_range(0, 3));
            k   = NL'($urandom);
            rp  = ($urandom_range(0, 3) == 0) ? 4'd0 : CW'($urandom_range(1, 15));
            on  = CW'($urandom_range(0, 3));
            off = CW'($urandom_range(0, 3));
            accept_cmd(m, k, rp, on, off, $urandom_range(1, 40));
            check_trace("random", exp_q.size(), done_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
